// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader: frame FSM encoding,
// receiver FSM encoding and the sync byte that opens every image frame.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling timer and shift register.
// Emits one-cycle rx_valid or rx_frame_err pulses at the stop-bit sample.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync2_q ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a checksummed program image over UART, writes it into instruction
// memory and releases the core from reset once the whole image is verified.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMEM_DEPTH   = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              boot_done,
    output logic              boot_err
);

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_DEPTH);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    boot_state_t       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        done_d     = done_q;
        err_d      = err_q;

        // Address steps once the write pulse ends; after the last word the FSM is in CSUM, so it never wraps.
        if (we_q && state_q == DATA) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (state_q == IDLE) begin
            addr_d     = '0;
            word_cnt_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
        end

        if (rx_frame_err && state_q != DONE) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        err_d   = 1'b0;
                        state_d = LEN0;
                    end
                end
                LEN0: begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN1;
                end
                LEN1: begin
                    len_d = {rx_data, len_q[7:0]};
                    if (len_d > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (len_d == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    word_d     = {rx_data, word_q[31:8]};
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wdata_d    = word_d;
                        we_d       = 1'b1;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_d == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_data == csum_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign boot_done  = done_q;
    assign core_reset = ~done_q;
    assign boot_err   = err_q;

endmodule
